// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller.
//   ADDR_W / DATA_W / CNT_W : default word-address, data and statistics widths
//   BLOCK_WORDS / OFFSET_W  : cache block geometry (4 words, 2 offset bits)
//   state_t                 : controller state encoding
package cache_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 16;
  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    UPDATE
  } state_t;

endpackage

// File: rtl/cache_refill_ctrl_sat_counter.sv
// Saturating event counter used for cache statistics.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   clr   : synchronous clear, wins over a same-cycle inc
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = cache_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  import cache_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-only, direct-mapped cache controller with 4-word block refill.
//   clk, rst                 : clock, asynchronous active-high reset
//   cpu_req/cpu_addr         : CPU read request, held until cpu_ack
//   cpu_ack/cpu_rdata        : one-cycle acknowledge with returned word
//   lkp_addr                 : address presented to the cache array
//   tag_hit/cache_rdata      : combinational lookup result from the array
//   fill_we/fill_addr/fill_data : word write into the data array
//   tag_we                   : mark block containing fill_addr valid
//   mem_rd_req/mem_addr      : one-cycle memory read strobe and address
//   mem_rd_valid/mem_rdata   : memory read response
//   stat_clr                 : clear both statistics counters
//   hit_count/miss_count     : saturating statistics
//   busy                     : controller not in IDLE
module cache_refill_ctrl #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W,
  parameter int CNT_W  = cache_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] lkp_addr,
  input  logic              tag_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              busy
);

  import cache_pkg::*;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [OFFSET_W-1:0] word_cnt;
  // Set while the lookup following a refill is pending; that lookup is
  // neither a hit nor a miss for statistics purposes.
  logic                relookup;

  logic [ADDR_W-1:0]   block_base;
  logic [ADDR_W-1:0]   word_addr;
  logic                lookup_hit;
  logic                lookup_miss;

  // Offset bits are replaced, never added, so the top block cannot wrap.
  assign block_base = {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign word_addr  = {req_addr[ADDR_W-1:OFFSET_W], word_cnt};

  assign lookup_hit  = (state == LOOKUP) && cpu_req && tag_hit;
  assign lookup_miss = (state == LOOKUP) && cpu_req && !tag_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
      word_cnt <= '0;
      relookup <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr <= cpu_addr;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          relookup <= 1'b0;
          if (!cpu_req || tag_hit) begin
            state <= IDLE;
          end else begin
            word_cnt <= '0;
            state    <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          state <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          // No timeout: the memory is trusted to answer eventually.
          if (mem_rd_valid) begin
            if (word_cnt == OFFSET_W'(BLOCK_WORDS - 1)) begin
              state <= UPDATE;
            end else begin
              word_cnt <= OFFSET_W'(word_cnt + 1);
              state    <= REFILL_REQ;
            end
          end
        end
        UPDATE: begin
          relookup <= 1'b1;
          state    <= LOOKUP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from the state register and the same-cycle
  // responses, so each one is naturally exclusive to a single state.
  // Data/address outputs are forced to zero whenever their strobe is low.
  always_comb begin
    cpu_ack    = 1'b0;
    cpu_rdata  = '0;
    mem_rd_req = 1'b0;
    mem_addr   = '0;
    fill_we    = 1'b0;
    fill_addr  = '0;
    fill_data  = '0;
    tag_we     = 1'b0;
    case (state)
      LOOKUP: begin
        if (cpu_req && tag_hit) begin
          cpu_ack   = 1'b1;
          cpu_rdata = cache_rdata;
        end
      end
      REFILL_REQ: begin
        mem_rd_req = 1'b1;
        mem_addr   = word_addr;
      end
      REFILL_WAIT: begin
        if (mem_rd_valid) begin
          fill_we   = 1'b1;
          fill_addr = word_addr;
          fill_data = mem_rdata;
        end
      end
      UPDATE: begin
        tag_we    = 1'b1;
        fill_addr = block_base;
      end
      default: begin
      end
    endcase
  end

  assign lkp_addr = req_addr;
  assign busy     = (state != IDLE);

  // Statistics: index 0 counts hits, index 1 counts misses.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = lookup_hit  && !relookup;
  assign cnt_inc[1] = lookup_miss && !relookup;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc[gi]),
        .clr   (stat_clr),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign hit_count  = cnt_val[0];
  assign miss_count = cnt_val[1];

endmodule
